// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared types and default widths for the mem_port_arbiter slice.
//   state_e : arbiter FSM states (IDLE, CMD, WAIT, RESP)
//   owner_e : which requester owns the transaction in flight
// Optional feature macro used by the slice: MEM_ARB_FAIRNESS_EN
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, data port, memory port and busy flag of the
//   arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            responses, the memory command and busy)
//   master : requester / memory-model view (the mirror image)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick
//   Combinational winner select between the fetch and data requesters.
//   Data wins a contested arbitration unless fetch has been starved.
//   Ports: clk, rst (async, active high), if_req, d_req, idle (grant window)
//          -> winner, if_gnt, d_gnt (one-cycle grant pulses).
//   MEM_ARB_FAIRNESS_EN defined: a saturating starvation counter forces a
//   fetch win after STARVE_MAX lost arbitrations. Undefined: strict data
//   priority, and clk/rst/STARVE_MAX go unused.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   idle,
  output owner_e winner,
  output logic   if_gnt,
  output logic   d_gnt
);

  logic force_if_s;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  // Count fetch losses in IDLE (saturating); a fetch grant clears the count.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = {CNT_W{1'b0}};
    end else if (if_req && d_gnt && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_if_s = (starve_q == CNT_MAX);
`else
  logic unused_s;
  assign unused_s   = clk ^ rst ^ (STARVE_MAX != 32'sd0);
  assign force_if_s = 1'b0;
`endif

  // Winner select and grant pulses; grants only open while idle.
  always_comb begin
    winner = OWN_D;
    if (if_req && d_req) begin
      winner = force_if_s ? OWN_IF : OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end else begin
      winner = OWN_D;
    end
    if_gnt = idle && if_req && (winner == OWN_IF);
    d_gnt  = idle && d_req  && (winner == OWN_D);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch port and the load/store data port. One transaction in flight:
//   IDLE (grant) -> CMD (mem_en) -> WAIT (MEM_LAT cycles) -> RESP (rvalid).
//   Ports: clk, rst (async, active high), bus (mem_port_arbiter_if.slave)
//          carrying the fetch, data and memory ports plus busy.
//   Optional feature macro: MEM_ARB_FAIRNESS_EN (fetch anti-starvation, see
//   mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, winner_s;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              busy_q, busy_d;
  logic              idle_s, lat_done_s, if_gnt_s, d_gnt_s;

  // Gate the grant window with rst so grants also read 0 while in reset.
  assign idle_s     = (state_q == IDLE) && !rst;
  assign lat_done_s = (state_q == WAIT) && (lat_q == LAT_LAST);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .idle   (idle_s),
    .winner (winner_s),
    .if_gnt (if_gnt_s),
    .d_gnt  (d_gnt_s)
  );

  // State, command, response and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= {LAT_W{1'b0}};
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic and the WAIT latency counter.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (if_gnt_s || d_gnt_s) begin
          state_d = CMD;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        state_d = WAIT;
        lat_d   = {LAT_W{1'b0}};
      end
      WAIT: begin
        if (lat_done_s) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          lat_d   = lat_q + LAT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command capture at grant, response capture at the end of WAIT, and the
  // next values of the registered outputs (aligned to state_d).
  always_comb begin
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    if (if_gnt_s || d_gnt_s) begin
      owner_d = winner_s;
      if (winner_s == OWN_IF) begin
        we_d    = 1'b0;
        addr_d  = bus.if_addr;
        wdata_d = {DATA_W{1'b0}};
      end else begin
        we_d    = bus.d_we;
        addr_d  = bus.d_addr;
        wdata_d = bus.d_wdata;
      end
    end else begin
      owner_d = owner_q;
    end

    // Stores return 0 on d_rdata instead of whatever the memory drives.
    if (lat_done_s) begin
      if (owner_q == OWN_IF) begin
        if_rdata_d = bus.mem_rdata;
      end else if (we_q) begin
        d_rdata_d = {DATA_W{1'b0}};
      end else begin
        d_rdata_d = bus.mem_rdata;
      end
    end else begin
      if_rdata_d = if_rdata_q;
    end

    mem_en_d    = (state_d == CMD);
    mem_we_d    = (state_d == CMD) && we_d;
    if_rvalid_d = (state_d == RESP) && (owner_q == OWN_IF);
    d_rvalid_d  = (state_d == RESP) && (owner_q == OWN_D);
    busy_d      = (state_d != IDLE);
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiters (MEM_LAT=1 and MEM_LAT=3) on a shared behavioural memory.
//   Expected responses are queued when a request is driven and compared when
//   rvalid appears. Contention expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

  localparam int MLA = 1;
  localparam int MLB = 3;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea;
  exp_t        eb;
  logic [31:0] ref_mem [256];
  logic [31:0] mem     [256];
  bit          mem_init_done = 1'b0;
  logic [31:0] pa;
  logic [31:0] pb [3];

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) ia ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) ib ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(MLA), .STARVE_MAX(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(MLB), .STARVE_MAX(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    return (i == 16) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Behavioural fixed-latency memory: A has 1 read stage, B has 3.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (ia.mem_en && ia.mem_we) begin
      mem[ia.mem_addr] <= ia.mem_wdata;
    end
    pa    <= mem[ia.mem_addr];
    pb[0] <= mem[ib.mem_addr];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign ia.mem_rdata = pa;
  assign ib.mem_rdata = pb[MLB-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void push_a(bit is_d, bit we, logic [7:0] addr, logic [31:0] wd);
    exp_t e;
    e.is_d = is_d;
    e.data = we ? 32'd0 : ref_mem[addr];
    if (we) ref_mem[addr] = wd;
    qa.push_back(e);
  endfunction

  function automatic void push_b(logic [7:0] addr);
    exp_t e;
    e.is_d = 1'b0;
    e.data = ref_mem[addr];
    qb.push_back(e);
  endfunction

  // Response scoreboard for instance A.
  always @(negedge clk) begin
    if (ia.if_rvalid || ia.d_rvalid) begin
      check_eq("a_rv_single", 32'(ia.if_rvalid & ia.d_rvalid), 32'd0);
      if (qa.size() == 0) begin
        check_eq("a_rv_unexpected", 32'(qa.size()), 32'd1);
      end else begin
        ea = qa.pop_front();
        check_eq("a_rv_port", 32'(ia.d_rvalid), 32'(ea.is_d));
        check_eq("a_rv_data", ea.is_d ? ia.d_rdata : ia.if_rdata, ea.data);
      end
    end
  end

  // Response scoreboard for instance B.
  always @(negedge clk) begin
    if (ib.if_rvalid || ib.d_rvalid) begin
      check_eq("b_rv_d", 32'(ib.d_rvalid), 32'd0);
      if (qb.size() == 0) begin
        check_eq("b_rv_unexpected", 32'(qb.size()), 32'd1);
      end else begin
        eb = qb.pop_front();
        check_eq("b_rv_data", ib.if_rdata, eb.data);
      end
    end
  end

  // One full transaction on instance A with timing checks.
  task automatic run_a(input bit is_d, input bit we, input logic [7:0] addr, input logic [31:0] wd);
    bit got;
    @(posedge clk); #1;
    if (is_d) begin
      ia.d_req = 1'b1; ia.d_we = we; ia.d_addr = addr; ia.d_wdata = wd;
    end else begin
      ia.if_req = 1'b1; ia.if_addr = addr;
    end
    push_a(is_d, we, addr, wd);
    got = 1'b0;
    for (int t = 0; t < 16 && !got; t++) begin
      @(negedge clk);
      got = is_d ? ia.d_gnt : ia.if_gnt;
    end
    check_eq("a_gnt", 32'(got), 32'd1);
    check_eq("a_gnt_other", 32'(is_d ? ia.if_gnt : ia.d_gnt), 32'd0);
    @(posedge clk); #1;
    ia.if_req = 1'b0; ia.d_req = 1'b0;
    @(negedge clk);
    check_eq("a_mem_en", 32'(ia.mem_en), 32'd1);
    check_eq("a_mem_we", 32'(ia.mem_we), 32'(we));
    check_eq("a_mem_addr", 32'(ia.mem_addr), 32'(addr));
    if (we) check_eq("a_mem_wdata", ia.mem_wdata, wd);
    repeat (MLA) @(negedge clk);
    check_eq("a_mem_en_wait", 32'(ia.mem_en), 32'd0);
    check_eq("a_rv_early", 32'(is_d ? ia.d_rvalid : ia.if_rvalid), 32'd0);
    @(negedge clk);
    check_eq("a_rv_at", 32'(is_d ? ia.d_rvalid : ia.if_rvalid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int last;
    bit got;
    bit exp_if;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    ia.if_req = 1'b0; ia.if_addr = 8'h00; ia.d_req = 1'b0; ia.d_we = 1'b0;
    ia.d_addr = 8'h00; ia.d_wdata = 32'h0;
    ib.if_req = 1'b0; ib.if_addr = 8'h00; ib.d_req = 1'b0; ib.d_we = 1'b0;
    ib.d_addr = 8'h00; ib.d_wdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(ia.busy), 32'd0);
    check_eq("rst_mem_en", 32'(ia.mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(ia.mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(ia.mem_addr), 32'd0);
    check_eq("rst_mem_wdata", ia.mem_wdata, 32'd0);
    check_eq("rst_if_rdata", ia.if_rdata, 32'd0);
    check_eq("rst_d_rdata", ia.d_rdata, 32'd0);
    check_eq("rst_rvalid", 32'({ia.if_rvalid, ia.d_rvalid}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single load, store, load-back, single fetch
    run_a(1'b1, 1'b0, 8'h10, 32'h0);
    run_a(1'b1, 1'b1, 8'h20, 32'h1234_5678);
    run_a(1'b1, 1'b0, 8'h20, 32'h0);
    run_a(1'b0, 1'b0, 8'h08, 32'h0);

    // contention: both held high, data re-requests back to back
    @(posedge clk); #1;
    ia.if_req = 1'b1; ia.if_addr = 8'h30;
    ia.d_req = 1'b1; ia.d_we = 1'b0; ia.d_addr = 8'h40;
    k = 0;
    last = 0;
    for (int c = 0; c < 80 && k < 10; c++) begin
      @(negedge clk);
      if (ia.if_gnt || ia.d_gnt) begin
`ifdef MEM_ARB_FAIRNESS_EN
        exp_if = ((k % 5) == 4);
`else
        exp_if = 1'b0;
`endif
        check_eq("ct_if_gnt", 32'(ia.if_gnt), 32'(exp_if));
        check_eq("ct_d_gnt", 32'(ia.d_gnt), 32'(!exp_if));
        if (k > 0) check_eq("ct_gap", 32'(c - last), 32'(MLA + 3));
        push_a(!exp_if, 1'b0, exp_if ? 8'h30 : 8'h40, 32'h0);
        last = c;
        k++;
      end
    end
    check_eq("ct_grants", 32'(k), 32'd10);
    @(posedge clk); #1;
    ia.if_req = 1'b0; ia.d_req = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      got = !ia.busy && (qa.size() == 0);
    end
    check_eq("a_drain", 32'(got), 32'd1);

    // MEM_LAT=3 fetch: rvalid exactly 5 cycles after grant, busy throughout
    @(posedge clk); #1;
    ib.if_req = 1'b1; ib.if_addr = 8'h04;
    push_b(8'h04);
    got = 1'b0;
    for (int t = 0; t < 16 && !got; t++) begin
      @(negedge clk);
      got = ib.if_gnt;
    end
    check_eq("b_gnt", 32'(got), 32'd1);
    check_eq("b_busy_at_gnt", 32'(ib.busy), 32'd0);
    @(posedge clk); #1;
    ib.if_req = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_eq("b_busy", 32'(ib.busy), 32'(i <= 5));
      check_eq("b_rvalid", 32'(ib.if_rvalid), 32'(i == 5));
    end

    // reset during WAIT aborts the transaction
    @(posedge clk); #1;
    ib.if_req = 1'b1; ib.if_addr = 8'h0C;
    push_b(8'h0C);
    got = 1'b0;
    for (int t = 0; t < 16 && !got; t++) begin
      @(negedge clk);
      got = ib.if_gnt;
    end
    check_eq("b2_gnt", 32'(got), 32'd1);
    @(posedge clk); #1;
    ib.if_req = 1'b0;
    @(negedge clk);
    check_eq("b2_mem_en", 32'(ib.mem_en), 32'd1);
    @(negedge clk);
    check_eq("b2_busy_wait", 32'(ib.busy), 32'd1);
    rst = 1'b1;
    ib.if_req = 1'b1; ib.if_addr = 8'h04;
    #1;
    check_eq("ar_busy", 32'(ib.busy), 32'd0);
    check_eq("ar_mem_en", 32'(ib.mem_en), 32'd0);
    check_eq("ar_mem_addr", 32'(ib.mem_addr), 32'd0);
    check_eq("ar_mem_wdata", ib.mem_wdata, 32'd0);
    check_eq("ar_if_rdata", ib.if_rdata, 32'd0);
    check_eq("ar_if_rvalid", 32'(ib.if_rvalid), 32'd0);
    check_eq("ar_if_gnt", 32'(ib.if_gnt), 32'd0);
    qb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    push_b(8'h04);
    @(negedge clk);
    check_eq("b_gnt_after_rst", 32'(ib.if_gnt), 32'd1);
    @(posedge clk); #1;
    ib.if_req = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      got = !ib.busy && (qb.size() == 0);
    end
    check_eq("b_drain", 32'(got), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
